// File: rtl/pipelined_addsub_n_if.sv
// Streaming operand/result bundle for the segmented add/sub unit.
// The per-beat sat input exists only when ADDSUB_SATURATE_EN is defined.
interface pipelined_addsub_n_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             sub;
`ifdef ADDSUB_SATURATE_EN
    logic             sat;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Overflow;

    modport master (
        output in_valid, A, B, sub,
`ifdef ADDSUB_SATURATE_EN
        output sat,
`endif
        output out_ready,
        input  in_ready, out_valid, Sum, Cout, Overflow
    );

    modport slave (
        input  in_valid, A, B, sub,
`ifdef ADDSUB_SATURATE_EN
        input  sat,
`endif
        input  out_ready,
        output in_ready, out_valid, Sum, Cout, Overflow
    );
endinterface

// File: rtl/pipelined_addsub_n.sv
// Segmented add/sub: one SEG-bit ripple per pipeline stage, global-stall valid/ready.
// Define ADDSUB_SATURATE_EN to add the per-beat sat input that clamps on signed overflow.
module addsub_seg #(parameter int SEG = 8) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] s,
    output logic           cout
);
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
endmodule

module pipelined_addsub_n #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    pipelined_addsub_n_if.slave io
);
    localparam int STAGES = WIDTH / SEG;

    logic                           adv;
    logic [STAGES:0]                vld_pipe;
    logic [STAGES-1:0]              vld_q;
    logic [STAGES-1:0][SEG-1:0]     seg_a, seg_b, seg_s;
    logic [STAGES-1:0]              seg_ci, seg_co;

    // Whole pipe advances together; in_ready never looks at in_valid.
    assign adv          = ~io.out_valid | io.out_ready;
    assign io.in_ready  = adv;
    assign vld_pipe     = {vld_q, io.in_valid};
    assign io.out_valid = vld_pipe[STAGES];

    always_ff @(posedge clk) begin
        if (!rst_n)   vld_q <= '0;
        else if (adv) vld_q <= vld_pipe[STAGES-1:0];
    end

    addsub_seg #(.SEG(SEG)) u_seg [STAGES-1:0] (
        .a    (seg_a),
        .b    (seg_b),
        .cin  (seg_ci),
        .s    (seg_s),
        .cout (seg_co)
    );

    // Stage k carries finished low segments in res and untouched high operand bits in opa/opb.
    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int LO = k * SEG;
        localparam int HI = LO + SEG;

        logic [WIDTH-1:LO] src_a, src_b;
        logic [HI-1:0]     res_nx;
        logic              src_c;
`ifdef ADDSUB_SATURATE_EN
        logic              src_sat;
`endif

        if (k == 0) begin : g_src
            assign src_a  = io.A;
            assign src_b  = io.B ^ {WIDTH{io.sub}};
            assign src_c  = io.sub;
            assign res_nx = seg_s[k];
`ifdef ADDSUB_SATURATE_EN
            assign src_sat = io.sat;
`endif
        end else begin : g_src
            assign src_a  = stg[k-1].g_mid.opa;
            assign src_b  = stg[k-1].g_mid.opb;
            assign src_c  = stg[k-1].g_mid.cy;
            assign res_nx = {seg_s[k], stg[k-1].g_mid.res};
`ifdef ADDSUB_SATURATE_EN
            assign src_sat = stg[k-1].g_mid.sat;
`endif
        end

        assign seg_a[k]  = src_a[HI-1:LO];
        assign seg_b[k]  = src_b[HI-1:LO];
        assign seg_ci[k] = src_c;

        if (k < STAGES - 1) begin : g_mid
            logic [WIDTH-1:HI] opa, opb;
            logic [HI-1:0]     res;
            logic              cy;
`ifdef ADDSUB_SATURATE_EN
            logic              sat;
`endif
            // Data is don't-care behind a bubble, so only adv gates the load.
            always_ff @(posedge clk) begin
                if (adv) begin
                    opa <= src_a[WIDTH-1:HI];
                    opb <= src_b[WIDTH-1:HI];
                    res <= res_nx;
                    cy  <= seg_co[k];
`ifdef ADDSUB_SATURATE_EN
                    sat <= src_sat;
`endif
                end
            end
        end else begin : g_last
            logic             ovf;
            logic [WIDTH-1:0] sum_fin;

            // carry into MSB recovered as a^b^s at that bit
            assign ovf = seg_co[k] ^ src_a[WIDTH-1] ^ src_b[WIDTH-1] ^ res_nx[WIDTH-1];
`ifdef ADDSUB_SATURATE_EN
            assign sum_fin = (src_sat && ovf) ?
                             {~res_nx[WIDTH-1], {(WIDTH-1){res_nx[WIDTH-1]}}} : res_nx;
`else
            assign sum_fin = res_nx;
`endif

            // Outputs only move on a real beat so they hold across bubbles.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    io.Sum      <= '0;
                    io.Cout     <= 1'b0;
                    io.Overflow <= 1'b0;
                end else if (adv && vld_pipe[k]) begin
                    io.Sum      <= sum_fin;
                    io.Cout     <= seg_co[k];
                    io.Overflow <= ovf;
                end
            end
        end
    end
endmodule

// File: tb/tb_pipelined_addsub_n.sv
// Directed bench for pipelined_addsub_n (WIDTH=32, SEG=8); saturation cases run when
// ADDSUB_SATURATE_EN is defined.
module tb_pipelined_addsub_n;
    localparam int WIDTH  = 32;
    localparam int SEG    = 8;
    localparam int STAGES = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    pipelined_addsub_n_if #(.WIDTH(WIDTH)) io ();

    pipelined_addsub_n #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    always #5 clk = ~clk;

    // Stream vectors: A, B, sub -> Sum, Cout, Overflow (hand-computed)
    logic [31:0] va [20] = '{32'h00000001, 32'h00000010, 32'h000000FF, 32'h0000FFFF, 32'h00FFFFFF,
                             32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h80000000, 32'h00000000,
                             32'h00000000, 32'h12345678, 32'h23456789, 32'hAAAAAAAA, 32'hAAAAAAAA,
                             32'h0000FF00, 32'h00FF0000, 32'h12345678, 32'h7FFFFFFF, 32'h80000000};
    logic [31:0] vb [20] = '{32'h00000002, 32'h00000001, 32'h00000001, 32'h00000001, 32'h00000001,
                             32'h00000002, 32'h00000001, 32'h7FFFFFFF, 32'h80000000, 32'h00000000,
                             32'h00000001, 32'h11111111, 32'h12345678, 32'h55555555, 32'h55555556,
                             32'h00000100, 32'h00010000, 32'h12345678, 32'hFFFFFFFF, 32'h7FFFFFFF};
    logic        vs [20] = '{0,1,0,0,0, 0,1,0,0,1, 1,0,1,0,0, 0,0,1,1,1};
    logic [31:0] es [20] = '{32'h00000003, 32'h0000000F, 32'h00000100, 32'h00010000, 32'h01000000,
                             32'h00000001, 32'h7FFFFFFF, 32'hFFFFFFFE, 32'h00000000, 32'h00000000,
                             32'hFFFFFFFF, 32'h23456789, 32'h11111111, 32'hFFFFFFFF, 32'h00000000,
                             32'h00010000, 32'h01000000, 32'h00000000, 32'h80000000, 32'h00000001};
    logic        ec [20] = '{0,1,0,0,0, 1,1,0,1,1, 0,0,1,0,1, 0,0,1,0,1};
    logic        ev [20] = '{0,0,0,0,0, 0,1,1,1,0, 0,0,0,0,0, 0,0,0,1,1};

    task automatic drive_idle;
        io.in_valid  = 1'b0;
        io.A         = '0;
        io.B         = '0;
        io.sub       = 1'b0;
`ifdef ADDSUB_SATURATE_EN
        io.sat       = 1'b0;
`endif
        io.out_ready = 1'b1;
    endtask

    task automatic flush;
        @(negedge clk);
        drive_idle();
        repeat (STAGES + 2) @(negedge clk);
    endtask

    // One beat with out_ready held high; lat counts edges from acceptance, -1 on timeout.
    task automatic run_beat(input logic [31:0] a, input logic [31:0] b, input logic s, input logic st,
                            output logic [31:0] sum, output logic co, output logic ov, output int lat);
        @(negedge clk);
        io.in_valid = 1'b1; io.A = a; io.B = b; io.sub = s; io.out_ready = 1'b1;
`ifdef ADDSUB_SATURATE_EN
        io.sat = st;
`endif
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        io.in_valid = 1'b0;
        while (!io.out_valid && lat < 20) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        if (!io.out_valid) lat = -1;
        sum = io.Sum; co = io.Cout; ov = io.Overflow;
    endtask

    task automatic test_reset;
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", io.out_valid); end
        checks++; if (io.Sum !== 32'h0) begin errors++; $display("FAIL reset_sum: got %h want 00000000", io.Sum); end
        checks++; if (io.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", io.in_ready); end
        checks++; if ({io.Cout, io.Overflow} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {io.Cout, io.Overflow}); end
    endtask

    task automatic test_add_carry;
        logic [31:0] sum; logic co, ov; int lat;
        flush();
        run_beat(32'h000000FF, 32'h00000001, 1'b0, 1'b0, sum, co, ov, lat);
        checks++; if (lat != STAGES) begin errors++; $display("FAIL add_latency: got %0d want %0d", lat, STAGES); end
        checks++; if (sum !== 32'h00000100) begin errors++; $display("FAIL add_carry_sum: got %h want 00000100", sum); end
        checks++; if ({co, ov} !== 2'b00) begin errors++; $display("FAIL add_carry_flags: got %b want 00", {co, ov}); end
    endtask

    task automatic test_wrap_overflow;
        logic [31:0] sum; logic co, ov; int lat;
        run_beat(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, sum, co, ov, lat);
        checks++; if (sum !== 32'h00000000 || lat != STAGES) begin errors++; $display("FAIL wrap_sum: got %h lat %0d want 00000000 lat %0d", sum, lat, STAGES); end
        checks++; if ({co, ov} !== 2'b10) begin errors++; $display("FAIL wrap_flags: got %b want 10", {co, ov}); end
        run_beat(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, sum, co, ov, lat);
        checks++; if (sum !== 32'h80000000) begin errors++; $display("FAIL ovf_sum: got %h want 80000000", sum); end
        checks++; if ({co, ov} !== 2'b01) begin errors++; $display("FAIL ovf_flags: got %b want 01", {co, ov}); end
    endtask

    task automatic test_sub;
        logic [31:0] sum; logic co, ov; int lat;
        run_beat(32'd5, 32'd7, 1'b1, 1'b0, sum, co, ov, lat);
        checks++; if (sum !== 32'hFFFFFFFE) begin errors++; $display("FAIL sub_neg_sum: got %h want FFFFFFFE", sum); end
        checks++; if ({co, ov} !== 2'b00) begin errors++; $display("FAIL sub_neg_flags: got %b want 00", {co, ov}); end
        run_beat(32'd7, 32'd5, 1'b1, 1'b0, sum, co, ov, lat);
        checks++; if (sum !== 32'h00000002) begin errors++; $display("FAIL sub_pos_sum: got %h want 00000002", sum); end
        checks++; if ({co, ov} !== 2'b10) begin errors++; $display("FAIL sub_pos_flags: got %b want 10", {co, ov}); end
    endtask

    task automatic test_back_to_back;
        int acc = 0, ret = 0, cyc = 0;
        logic held = 1'b0, take;
        logic [31:0] hs; logic hc, hv;
        int extra = 0;
        flush();
        while (ret < 20 && cyc < 300) begin
            @(negedge clk);
            io.out_ready = (cyc % 3 == 0);
            io.in_valid  = (acc < 20);
            if (acc < 20) begin io.A = va[acc]; io.B = vb[acc]; io.sub = vs[acc]; end
            #1;
            if (held) begin
                checks++;
                if (!io.out_valid || io.Sum !== hs || io.Cout !== hc || io.Overflow !== hv) begin
                    errors++;
                    $display("FAIL stall_stable: got v%b %h %b%b want v1 %h %b%b", io.out_valid, io.Sum, io.Cout, io.Overflow, hs, hc, hv);
                end
            end
            held = io.out_valid && !io.out_ready;
            hs = io.Sum; hc = io.Cout; hv = io.Overflow;
            if (io.out_valid && io.out_ready) begin
                checks++;
                if ({io.Sum, io.Cout, io.Overflow} !== {es[ret], ec[ret], ev[ret]}) begin
                    errors++;
                    $display("FAIL stream_beat%0d: got %h %b%b want %h %b%b", ret, io.Sum, io.Cout, io.Overflow, es[ret], ec[ret], ev[ret]);
                end
                ret++;
            end
            take = io.in_valid && io.in_ready;
            @(posedge clk);
            if (take) acc++;
            cyc++;
        end
        checks++; if (ret != 20) begin errors++; $display("FAIL stream_count: got %0d results want 20", ret); end
        @(negedge clk);
        drive_idle();
        repeat (8) begin @(negedge clk); if (io.out_valid) extra++; end
        checks++; if (extra != 0) begin errors++; $display("FAIL stream_no_dup: got %0d extra valid cycles want 0", extra); end
    endtask

    task automatic test_reset_mid;
        int stale = 0;
        flush();
        for (int i = 0; i < 3; i++) begin
            io.in_valid = 1'b1; io.A = 32'(i + 1); io.B = 32'(i); io.sub = 1'b0;
            @(negedge clk);
        end
        io.in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (io.out_valid !== 1'b0 || io.Sum !== 32'h0) begin errors++; $display("FAIL midreset_clear: got v%b %h want v0 00000000", io.out_valid, io.Sum); end
        repeat (8) begin @(negedge clk); if (io.out_valid) stale++; end
        checks++; if (stale != 0) begin errors++; $display("FAIL midreset_stale: got %0d valid cycles want 0", stale); end
    endtask

`ifdef ADDSUB_SATURATE_EN
    task automatic test_saturate;
        logic [31:0] sum; logic co, ov; int lat;
        flush();
        run_beat(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, sum, co, ov, lat);
        checks++; if (sum !== 32'h7FFFFFFF) begin errors++; $display("FAIL sat_pos_sum: got %h want 7FFFFFFF", sum); end
        checks++; if (ov !== 1'b1) begin errors++; $display("FAIL sat_pos_ovf: got %b want 1", ov); end
        run_beat(32'h80000000, 32'h00000001, 1'b1, 1'b1, sum, co, ov, lat);
        checks++; if (sum !== 32'h80000000) begin errors++; $display("FAIL sat_neg_sum: got %h want 80000000", sum); end
        checks++; if ({co, ov} !== 2'b11) begin errors++; $display("FAIL sat_neg_flags: got %b want 11", {co, ov}); end
    endtask
`endif

    initial begin
        test_reset();
        test_add_carry();
        test_wrap_overflow();
        test_sub();
        test_back_to_back();
        test_reset_mid();
`ifdef ADDSUB_SATURATE_EN
        test_saturate();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
